// File: rtl/alu_share_ctrl_if.sv
// Requester-side port of the shared ALU controller: request channel plus
// valid/ready response channel carrying result, zero flag and illegal-op flag.
interface alu_share_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  oprn;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_zero;
  logic        rsp_err;

  modport master (
    output req_valid, oprn, op1, op2, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, oprn, op1, op2, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one combinational ALU between requesters A (index 0)
// and B (index 1); operands are held on the ALU for a fixed settle time.
module alu_share_ctrl #(
  parameter int ALU_WAIT = 1,
  parameter int MUL_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_share_ctrl_if.slave     a,
  alu_share_ctrl_if.slave     b,
  output logic [5:0]          alu_oprn,
  output logic [31:0]         alu_op1,
  output logic [31:0]         alu_op2,
  input  logic [31:0]         alu_out,
  input  logic                alu_zero
);
  localparam int         NUM_REQ = 2;
  localparam logic [5:0] OP_MUL  = 6'h3;
  localparam logic [3:0] ALU_CNT = 4'(ALU_WAIT - 1);
  localparam logic [3:0] MUL_CNT = 4'(MUL_WAIT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state_q, state_d;

  logic [NUM_REQ-1:0]       req_valid, rsp_ready, gnt;
  logic [NUM_REQ-1:0][5:0]  oprn;
  logic [NUM_REQ-1:0][31:0] op1, op2;
  logic [NUM_REQ-1:0]       rsp_valid_q, rsp_zero_q, rsp_err_q;
  logic [NUM_REQ-1:0][31:0] rsp_data_q;

  logic       owner_q, last_gnt_q, sel, sel_legal;
  logic [3:0] cnt_q;

  assign req_valid = {b.req_valid, a.req_valid};
  assign rsp_ready = {b.rsp_ready, a.rsp_ready};
  assign oprn      = {b.oprn, a.oprn};
  assign op1       = {b.op1, a.op1};
  assign op2       = {b.op2, a.op2};

  assign a.req_ready = gnt[0];
  assign a.rsp_valid = rsp_valid_q[0];
  assign a.rsp_data  = rsp_data_q[0];
  assign a.rsp_zero  = rsp_zero_q[0];
  assign a.rsp_err   = rsp_err_q[0];
  assign b.req_ready = gnt[1];
  assign b.rsp_valid = rsp_valid_q[1];
  assign b.rsp_data  = rsp_data_q[1];
  assign b.rsp_zero  = rsp_zero_q[1];
  assign b.rsp_err   = rsp_err_q[1];

  // A wins unless only B is valid or A was granted last.
  assign sel       = (req_valid[0] && (!req_valid[1] || last_gnt_q)) ? 1'b0 : 1'b1;
  assign sel_legal = (oprn[sel] != 6'h0) && (oprn[sel] <= 6'h9);

  always_comb begin
    state_d = state_q;
    gnt     = '0;
    case (state_q)
      IDLE: if (rst_n && |req_valid) begin
        gnt[sel] = 1'b1;
        state_d  = sel_legal ? EXEC : RESP;
      end
      EXEC: if (cnt_q == 4'd0) state_d = RESP;
      RESP: if (rsp_ready[owner_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_gnt_q  <= 1'b1;
      cnt_q       <= '0;
      alu_oprn    <= '0;
      alu_op1     <= '0;
      alu_op2     <= '0;
      rsp_valid_q <= '0;
      rsp_zero_q  <= '0;
      rsp_err_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (|gnt) begin
          owner_q    <= sel;
          last_gnt_q <= sel;
          cnt_q      <= (oprn[sel] == OP_MUL) ? MUL_CNT : ALU_CNT;
          if (sel_legal) begin
            alu_oprn <= oprn[sel];
            alu_op1  <= op1[sel];
            alu_op2  <= op2[sel];
          end else begin
            // Illegal opcodes never reach the ALU; answer immediately.
            rsp_data_q[sel]  <= '0;
            rsp_zero_q[sel]  <= 1'b1;
            rsp_err_q[sel]   <= 1'b1;
            rsp_valid_q[sel] <= 1'b1;
          end
        end
        EXEC: if (cnt_q != 4'd0) begin
          cnt_q <= cnt_q - 4'd1;
        end else begin
          rsp_data_q[owner_q]  <= alu_out;
          rsp_zero_q[owner_q]  <= alu_zero;
          rsp_err_q[owner_q]   <= 1'b0;
          rsp_valid_q[owner_q] <= 1'b1;
          alu_oprn             <= '0;
          alu_op1              <= '0;
          alu_op2              <= '0;
        end
        RESP: if (rsp_ready[owner_q]) rsp_valid_q[owner_q] <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural model of the shared ALU.
module tb_alu_share_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  alu_oprn;
  logic [31:0] alu_op1, alu_op2, alu_out;
  logic        alu_zero;
  int          n_chk = 0, n_pass = 0, n_fail = 0;

  alu_share_ctrl_if a_bus();
  alu_share_ctrl_if b_bus();

  alu_share_ctrl #(.ALU_WAIT(1), .MUL_WAIT(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a_bus.slave),
    .b        (b_bus.slave),
    .alu_oprn (alu_oprn),
    .alu_op1  (alu_op1),
    .alu_op2  (alu_op2),
    .alu_out  (alu_out),
    .alu_zero (alu_zero)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_out = '0;
    case (alu_oprn)
      6'h1: alu_out = alu_op1 + alu_op2;
      6'h2: alu_out = alu_op1 - alu_op2;
      6'h3: alu_out = alu_op1 * alu_op2;
      6'h4: alu_out = alu_op1 >> alu_op2;
      6'h5: alu_out = alu_op1 << alu_op2;
      6'h6: alu_out = alu_op1 & alu_op2;
      6'h7: alu_out = alu_op1 | alu_op2;
      6'h8: alu_out = ~(alu_op1 | alu_op2);
      6'h9: alu_out = {31'b0, $signed(alu_op1) < $signed(alu_op2)};
      default: alu_out = '0;
    endcase
    alu_zero = (alu_out == 32'h0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_a(input logic v, input logic [5:0] o, input logic [31:0] x, input logic [31:0] y);
    a_bus.req_valid = v; a_bus.oprn = o; a_bus.op1 = x; a_bus.op2 = y;
  endtask

  task automatic set_b(input logic v, input logic [5:0] o, input logic [31:0] x, input logic [31:0] y);
    b_bus.req_valid = v; b_bus.oprn = o; b_bus.op1 = x; b_bus.op2 = y;
  endtask

  task automatic hs_a();
    a_bus.rsp_ready = 1'b1; step(); a_bus.rsp_ready = 1'b0;
  endtask

  task automatic hs_b();
    b_bus.rsp_ready = 1'b1; step(); b_bus.rsp_ready = 1'b0;
  endtask

  initial begin
    set_a(0, 6'h0, 0, 0); a_bus.rsp_ready = 1'b0;
    set_b(0, 6'h0, 0, 0); b_bus.rsp_ready = 1'b0;
    #2;
    chk("rst_a_ready", a_bus.req_ready, 0);
    chk("rst_a_rsp_valid", a_bus.rsp_valid, 0);
    chk("rst_b_rsp_valid", b_bus.rsp_valid, 0);
    chk("rst_a_data", a_bus.rsp_data, 0);
    chk("rst_a_zero", a_bus.rsp_zero, 0);
    chk("rst_a_err", a_bus.rsp_err, 0);
    chk("rst_alu_oprn", alu_oprn, 0);
    chk("rst_alu_op1", alu_op1, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Tie straight out of reset: A first, then round-robin hands B the next tie
    set_a(1, 6'h2, 9, 9); set_b(1, 6'h7, 32'hF0, 32'h0F); #1;
    chk("t2_a_ready", a_bus.req_ready, 1);
    chk("t2_b_ready", b_bus.req_ready, 0);
    step();
    set_a(1, 6'h1, 1, 1);
    chk("t2_exec_oprn", alu_oprn, 2);
    chk("t2_exec_a_ready", a_bus.req_ready, 0);
    chk("t2_exec_b_ready", b_bus.req_ready, 0);
    step();
    chk("t2_a_valid", a_bus.rsp_valid, 1);
    chk("t2_a_data", a_bus.rsp_data, 0);
    chk("t2_a_zero", a_bus.rsp_zero, 1);
    chk("t2_a_err", a_bus.rsp_err, 0);
    hs_a();
    chk("t2_rr_b_ready", b_bus.req_ready, 1);
    chk("t2_rr_a_ready", a_bus.req_ready, 0);
    chk("t2_a_valid_drop", a_bus.rsp_valid, 0);
    step();
    b_bus.req_valid = 1'b0;
    step();
    chk("t2_b_valid", b_bus.rsp_valid, 1);
    chk("t2_b_data", b_bus.rsp_data, 32'hFF);
    chk("t2_b_zero", b_bus.rsp_zero, 0);
    chk("t2_a_nonowner", a_bus.rsp_valid, 0);
    hs_b();
    chk("t2_a_ready2", a_bus.req_ready, 1);
    step();
    a_bus.req_valid = 1'b0;
    step();
    chk("t2_a_data2", a_bus.rsp_data, 2);
    hs_a();
    chk("t2_b_data_hold", b_bus.rsp_data, 32'hFF);

    // A alone: 5+7
    set_a(1, 6'h1, 5, 7); #1;
    chk("t1_a_ready", a_bus.req_ready, 1);
    chk("t1_b_ready", b_bus.req_ready, 0);
    step();
    a_bus.req_valid = 1'b0;
    chk("t1_alu_oprn", alu_oprn, 1);
    chk("t1_alu_op1", alu_op1, 5);
    chk("t1_valid_early", a_bus.rsp_valid, 0);
    step();
    chk("t1_valid", a_bus.rsp_valid, 1);
    chk("t1_data", a_bus.rsp_data, 12);
    chk("t1_zero", a_bus.rsp_zero, 0);
    chk("t1_err", a_bus.rsp_err, 0);
    chk("t1_alu_clear", alu_oprn, 0);
    hs_a();
    chk("t1_valid_drop", a_bus.rsp_valid, 0);

    // B mul 6*7: operands stable for four cycles, response on the fourth edge
    set_b(1, 6'h3, 6, 7); #1;
    chk("t3_b_ready", b_bus.req_ready, 1);
    step();
    b_bus.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t3_oprn", alu_oprn, 3);
      chk("t3_op1", alu_op1, 6);
      chk("t3_op2", alu_op2, 7);
      chk("t3_valid_early", b_bus.rsp_valid, 0);
      step();
    end
    chk("t3_valid", b_bus.rsp_valid, 1);
    chk("t3_data", b_bus.rsp_data, 42);
    chk("t3_alu_clear", alu_oprn, 0);
    hs_b();

    // Illegal opcodes 0x0 and 0x2A
    set_a(1, 6'h0, 3, 4); #1;
    chk("t4_ready0", a_bus.req_ready, 1);
    step();
    a_bus.req_valid = 1'b0;
    chk("t4_valid0", a_bus.rsp_valid, 1);
    chk("t4_err0", a_bus.rsp_err, 1);
    chk("t4_data0", a_bus.rsp_data, 0);
    chk("t4_zero0", a_bus.rsp_zero, 1);
    chk("t4_alu0", alu_oprn, 0);
    hs_a();
    set_a(1, 6'h2A, 3, 4); step();
    a_bus.req_valid = 1'b0;
    chk("t4_valid2a", a_bus.rsp_valid, 1);
    chk("t4_err2a", a_bus.rsp_err, 1);
    chk("t4_data2a", a_bus.rsp_data, 0);
    chk("t4_zero2a", a_bus.rsp_zero, 1);
    chk("t4_alu2a", alu_oprn, 0);
    hs_a();
    chk("t4_alu_after", alu_oprn, 0);

    // A response back-pressured for ten cycles while B waits
    set_a(1, 6'h1, 3, 4); step();
    a_bus.req_valid = 1'b0;
    set_b(1, 6'h1, 1, 1);
    step();
    for (int i = 0; i < 10; i++) begin
      chk("t5_a_valid_hold", a_bus.rsp_valid, 1);
      chk("t5_a_data_hold", a_bus.rsp_data, 7);
      chk("t5_b_blocked", b_bus.req_ready, 0);
      step();
    end
    a_bus.rsp_ready = 1'b1; #1;
    chk("t5_b_blocked_hs", b_bus.req_ready, 0);
    step();
    a_bus.rsp_ready = 1'b0;
    chk("t5_b_ready", b_bus.req_ready, 1);
    chk("t5_a_valid_drop", a_bus.rsp_valid, 0);
    step();
    b_bus.req_valid = 1'b0;
    step();
    chk("t5_b_data", b_bus.rsp_data, 2);
    hs_b();

    // Reset in the middle of a mul
    set_a(1, 6'h3, 2, 3); step();
    a_bus.req_valid = 1'b0;
    step();
    chk("t6_mid_exec", alu_oprn, 3);
    rst_n = 1'b0; #1;
    chk("t6_alu_oprn", alu_oprn, 0);
    chk("t6_alu_op1", alu_op1, 0);
    chk("t6_a_valid", a_bus.rsp_valid, 0);
    chk("t6_a_data", a_bus.rsp_data, 0);
    chk("t6_b_data", b_bus.rsp_data, 0);
    set_a(1, 6'h1, 1, 2); set_b(1, 6'h1, 3, 4); #1;
    chk("t6_a_ready_in_rst", a_bus.req_ready, 0);
    chk("t6_b_ready_in_rst", b_bus.req_ready, 0);
    step(); step();
    rst_n = 1'b1; #1;
    chk("t6_a_wins", a_bus.req_ready, 1);
    chk("t6_b_loses", b_bus.req_ready, 0);
    a_bus.req_valid = 1'b0; b_bus.req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t6_a_no_rsp", a_bus.rsp_valid, 0);
      chk("t6_b_no_rsp", b_bus.rsp_valid, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
